// File: rtl/cfg_page_sequencer.sv
// Flash configuration page sequencer: boot-page read, PFL reconfigure, done wait.
// Optional CFG_SEQ_FALLBACK_EN: on a failed page fall back to last good, then factory.
module cfg_page_sequencer #(
    parameter int NUM_PAGES = 3,
    parameter int PAGE_W    = 2,
    parameter int CFG_CYC   = 2**24-1,
    parameter int RST_CYC   = 2**24-1,
    parameter int WAIT_CYC  = 2**28-1,
    parameter int MAX_RETRY = 2
) (
    input  logic              clkin_max_100,
    input  logic              sys_reset,
    input  logic              fpga_conf_done,
    input  logic              page_next,
    input  logic              oper_compl,
    input  logic [PAGE_W-1:0] boot_page,
    output logic              pfl_access,
    output logic              fl_req,
    output logic [2:0]        fpga_pgm,
    output logic              pfl_nreconfigure,
    output logic              pfl_nreset,
    output logic              busy,
    output logic              cfg_error,
    output logic [PAGE_W-1:0] good_page
);

    localparam int CFG_W  = $clog2(CFG_CYC + 1);
    localparam int RST_W  = $clog2(RST_CYC + 1);
    localparam int WAIT_W = $clog2(WAIT_CYC + 1);
    localparam int RTY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CFG_W-1:0]  CFG_LAST = CFG_W'(CFG_CYC - 1);
    localparam logic [RST_W-1:0]  RST_LAST = RST_W'(RST_CYC - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_CYC);
    localparam logic [RTY_W-1:0]  RTY_LIM  = RTY_W'(MAX_RETRY);
    localparam logic [PAGE_W-1:0] LAST_PG  = PAGE_W'(NUM_PAGES - 1);
    localparam logic [PAGE_W:0]   NPAGES   = (PAGE_W+1)'(NUM_PAGES);

    typedef enum logic [2:0] {
        BOOT_WAIT,
        BOOT_READ,
        RECONF,
        PFL_RST,
        WAIT_DONE,
        IDLE,
        FAULT
    } state_t;

    state_t             state, state_nxt;
    logic [PAGE_W-1:0]  page, page_nxt, good_nxt;
    logic [RTY_W-1:0]   retry, retry_nxt;
    logic               err_nxt;
    logic [CFG_W-1:0]   cfg_cnt;
    logic [RST_W-1:0]   rst_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               cd_s1, cd_s2;
    logic               done;
    logic               boot_ok;

    assign done    = cd_s2;
    assign boot_ok = {1'b0, boot_page} < NPAGES;

    always_ff @(posedge clkin_max_100 or posedge sys_reset) begin
        if (sys_reset) begin
            cd_s1 <= 1'b0;
            cd_s2 <= 1'b0;
        end else begin
            cd_s1 <= fpga_conf_done;
            cd_s2 <= cd_s1;
        end
    end

    always_ff @(posedge clkin_max_100 or posedge sys_reset) begin
        if (sys_reset) begin
            state     <= BOOT_WAIT;
            page      <= '0;
            good_page <= '0;
            retry     <= '0;
            cfg_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            page      <= page_nxt;
            good_page <= good_nxt;
            retry     <= retry_nxt;
            cfg_error <= err_nxt;
        end
    end

    // Counters run only while the state holds, so each one is zero on entry.
    always_ff @(posedge clkin_max_100 or posedge sys_reset) begin
        if (sys_reset) begin
            cfg_cnt  <= '0;
            rst_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            cfg_cnt  <= (state == RECONF && state_nxt == RECONF)
                        ? cfg_cnt + 1'b1 : '0;
            rst_cnt  <= (state == PFL_RST && state_nxt == PFL_RST)
                        ? rst_cnt + 1'b1 : '0;
            wait_cnt <= (state == WAIT_DONE && state_nxt == WAIT_DONE)
                        ? wait_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        page_nxt  = page;
        good_nxt  = good_page;
        retry_nxt = retry;
        err_nxt   = cfg_error;
        unique case (state)
            BOOT_WAIT: begin
                if (done) state_nxt = BOOT_READ;
            end
            BOOT_READ: begin
                if (oper_compl) begin
                    page_nxt  = boot_ok ? boot_page : '0;
                    good_nxt  = boot_ok ? boot_page : '0;
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (page_next) begin
                    page_nxt  = (page >= LAST_PG) ? PAGE_W'(1) : page + 1'b1;
                    retry_nxt = '0;
                    state_nxt = RECONF;
                end
            end
            RECONF: begin
                if (cfg_cnt == CFG_LAST) state_nxt = PFL_RST;
            end
            PFL_RST: begin
                if (rst_cnt == RST_LAST) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done && wait_cnt < WAIT_LIM) begin
                    good_nxt  = page;
                    retry_nxt = '0;
                    state_nxt = IDLE;
                end else if (wait_cnt == WAIT_LIM) begin
                    if (retry < RTY_LIM) begin
                        retry_nxt = retry + 1'b1;
                        state_nxt = RECONF;
                    end else begin
`ifdef CFG_SEQ_FALLBACK_EN
                        if (page == '0) begin
                            err_nxt   = 1'b1;
                            state_nxt = FAULT;
                        end else begin
                            page_nxt  = (page == good_page) ? '0 : good_page;
                            retry_nxt = '0;
                            state_nxt = RECONF;
                        end
`else
                        err_nxt   = 1'b1;
                        state_nxt = FAULT;
`endif
                    end
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = BOOT_WAIT;
            end
        endcase
    end

    // Outputs decode straight from state so reset takes effect without a clock.
    assign pfl_access       = (state != BOOT_READ);
    assign fl_req           = (state != BOOT_READ);
    assign pfl_nreconfigure = (state != RECONF);
    assign pfl_nreset       = (state != PFL_RST);
    assign busy             = (state != IDLE) && (state != FAULT);
    assign fpga_pgm         = 3'(page);

endmodule

// File: tb/tb_cfg_page_sequencer.sv
// Bench for cfg_page_sequencer: boot, advance, retry/fallback, fault and reset.
// Expected page results are queued at stimulus time and checked on completion.
module tb_cfg_page_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       conf_done = 1'b0;
    logic       page_next = 1'b0;
    logic       oper_compl = 1'b0;
    logic [1:0] boot_page = 2'd0;
    logic       pfl_access, fl_req, nreconf, nreset, busy, cfg_error;
    logic [2:0] fpga_pgm;
    logic [1:0] good_page;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] pgm;
        logic [1:0] good;
        logic       err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cfg_page_sequencer #(
        .NUM_PAGES(3), .PAGE_W(2), .CFG_CYC(4),
        .RST_CYC(4), .WAIT_CYC(16), .MAX_RETRY(2)
    ) dut (
        .clkin_max_100   (clk),
        .sys_reset       (rst),
        .fpga_conf_done  (conf_done),
        .page_next       (page_next),
        .oper_compl      (oper_compl),
        .boot_page       (boot_page),
        .pfl_access      (pfl_access),
        .fl_req          (fl_req),
        .fpga_pgm        (fpga_pgm),
        .pfl_nreconfigure(nreconf),
        .pfl_nreset      (nreset),
        .busy            (busy),
        .cfg_error       (cfg_error),
        .good_page       (good_page)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        conf_done = 1'b0;
        page_next = 1'b0;
        oper_compl = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            cyc(1);
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic boot(input logic [1:0] bp, input logic [2:0] ep,
                        output bit ok);
        int n = 0;
        conf_done = 1'b1;
        while (fl_req !== 1'b0 && n < 20) begin
            cyc(1);
            n++;
        end
        ok = (fl_req === 1'b0);
        sb.push_back('{pgm: ep, good: ep[1:0], err: 1'b0});
        oper_compl = 1'b1;
        boot_page = bp;
        cyc(1);
        oper_compl = 1'b0;
        boot_page = 2'd0;
    endtask

    task automatic count_low(input int which, input logic [2:0] ep,
                             output int len, output bit pgm_ok);
        int n = 0;
        len = 0;
        pgm_ok = 1'b1;
        while (n < 100 && (which == 0 ? nreconf : nreset) !== 1'b0) begin
            cyc(1);
            n++;
        end
        while (len < 50 && (which == 0 ? nreconf : nreset) === 1'b0) begin
            if (fpga_pgm !== ep) pgm_ok = 1'b0;
            page_next = (which == 0 && len == 1);
            cyc(1);
            len++;
        end
        page_next = 1'b0;
    endtask

    task automatic run_advance(input logic [2:0] ep);
        int  lc, lr;
        bit  p1, p2, ok;
        exp_t e;
        sb.push_back('{pgm: ep, good: ep[1:0], err: 1'b0});
        conf_done = 1'b0;
        page_next = 1'b1;
        cyc(1);
        page_next = 1'b0;
        count_low(0, ep, lc, p1);
        count_low(1, ep, lr, p2);
        cyc(2);
        conf_done = 1'b1;
        wait_idle(ok);
        e = sb.pop_front();
        total++;
        if (lc != 4) begin
            bad++;
            $display("FAIL nreconf_len: got %0d want 4", lc);
        end
        total++;
        if (lr != 4) begin
            bad++;
            $display("FAIL nreset_len: got %0d want 4", lr);
        end
        total++;
        if (!(p1 && p2)) begin
            bad++;
            $display("FAIL pgm_stable: pgm moved from %0d during sequence", ep);
        end
        total++;
        if (!ok || {fpga_pgm, good_page, cfg_error} !== e) begin
            bad++;
            $display("FAIL advance_result: got pgm=%0d good=%0d err=%0b busy=%0b want pgm=%0d good=%0d err=%0b",
                     fpga_pgm, good_page, cfg_error, busy, e.pgm, e.good, e.err);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({pfl_access, fl_req, nreconf, nreset, busy, cfg_error} !== 6'b111110) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 111110",
                     {pfl_access, fl_req, nreconf, nreset, busy, cfg_error});
        end
        total++;
        if ({fpga_pgm, good_page} !== 5'd0) begin
            bad++;
            $display("FAIL reset_page: got pgm=%0d good=%0d want 0 0", fpga_pgm, good_page);
        end
        rst = 1'b0;
        cyc(5);
        total++;
        if ({busy, fl_req, pfl_access} !== 3'b111) begin
            bad++;
            $display("FAIL boot_wait_hold: got %b want 111", {busy, fl_req, pfl_access});
        end
    endtask

    task automatic test_boot(input logic [1:0] bp, input logic [2:0] ep);
        bit   ok;
        exp_t e;
        do_reset();
        boot(bp, ep, ok);
        e = sb.pop_front();
        total++;
        if (!ok || {fpga_pgm, good_page, cfg_error} !== e) begin
            bad++;
            $display("FAIL boot_%0d: got pgm=%0d good=%0d err=%0b want pgm=%0d good=%0d",
                     bp, fpga_pgm, good_page, cfg_error, e.pgm, e.good);
        end
        total++;
        if ({pfl_access, fl_req, busy} !== 3'b110) begin
            bad++;
            $display("FAIL boot_idle_ctrl: got %b want 110", {pfl_access, fl_req, busy});
        end
    endtask

    task automatic test_advance();
        run_advance(3'd1);
    endtask

    task automatic test_back_to_back();
        run_advance(3'd1);
        run_advance(3'd2);
        run_advance(3'd1);
    endtask

    task automatic test_retry();
        int   lc, lr, good_passes;
        bit   p1, p2, ok;
        exp_t e;
`ifdef CFG_SEQ_FALLBACK_EN
        sb.push_back('{pgm: 3'd2, good: 2'd2, err: 1'b0});
`else
        sb.push_back('{pgm: 3'd1, good: 2'd2, err: 1'b1});
`endif
        good_passes = 0;
        conf_done = 1'b0;
        page_next = 1'b1;
        cyc(1);
        page_next = 1'b0;
        for (int p = 0; p < 3; p++) begin
            count_low(0, 3'd1, lc, p1);
            count_low(1, 3'd1, lr, p2);
            if (lc == 4 && lr == 4 && p1 && p2) good_passes++;
        end
        total++;
        if (good_passes != 3) begin
            bad++;
            $display("FAIL retry_passes: got %0d want 3", good_passes);
        end
`ifdef CFG_SEQ_FALLBACK_EN
        count_low(0, 3'd2, lc, p1);
        total++;
        if (lc != 4 || !p1) begin
            bad++;
            $display("FAIL fallback_pgm: len=%0d pgm=%0d want len=4 pgm=2", lc, fpga_pgm);
        end
        conf_done = 1'b1;
`endif
        wait_idle(ok);
        e = sb.pop_front();
        total++;
        if (!ok || {fpga_pgm, good_page, cfg_error} !== e) begin
            bad++;
            $display("FAIL retry_result: got pgm=%0d good=%0d err=%0b want pgm=%0d good=%0d err=%0b",
                     fpga_pgm, good_page, cfg_error, e.pgm, e.good, e.err);
        end
`ifndef CFG_SEQ_FALLBACK_EN
        p1 = 1'b1;
        page_next = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (nreconf !== 1'b1 || busy !== 1'b0) p1 = 1'b0;
            if (i == 3) page_next = 1'b0;
            cyc(1);
        end
        total++;
        if (!p1 || {fpga_pgm, cfg_error, pfl_access, nreset} !== 6'b001111) begin
            bad++;
            $display("FAIL fault_hold: stable=%0b got %b want 001111",
                     p1, {fpga_pgm, cfg_error, pfl_access, nreset});
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit   ok;
        exp_t e;
        do_reset();
        boot(2'd2, 3'd2, ok);
        e = sb.pop_front();
        total++;
        if (!ok || {fpga_pgm, good_page} !== {e.pgm, e.good}) begin
            bad++;
            $display("FAIL mid_boot: got pgm=%0d good=%0d want 2 2", fpga_pgm, good_page);
        end
        conf_done = 1'b0;
        page_next = 1'b1;
        cyc(1);
        page_next = 1'b0;
        cyc(1);
        total++;
        if (nreconf !== 1'b0) begin
            bad++;
            $display("FAIL mid_in_reconf: nreconf=%0b want 0", nreconf);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({nreconf, nreset, busy, fl_req, pfl_access, fpga_pgm, good_page} !== 10'b11111_00000) begin
            bad++;
            $display("FAIL mid_async_reset: got %b want 1111100000",
                     {nreconf, nreset, busy, fl_req, pfl_access, fpga_pgm, good_page});
        end
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_boot(2'd2, 3'd2);
        test_advance();
        test_boot(2'd3, 3'd0);
        test_back_to_back();
        test_boot(2'd2, 3'd2);
        test_retry();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cfg_page_sequencer.md
CFG_PAGE_SEQUENCER -- requirements
Module: cfg_page_sequencer

Interface
REQ-001 SHALL have parameter NUM_PAGES, default 3: number of flash config pages; page 0 = factory, 1..NUM_PAGES-1 = user.
REQ-002 SHALL have parameter PAGE_W, default 2: page index width; NUM_PAGES <= 2**PAGE_W.
REQ-003 SHALL have parameter CFG_CYC, default 2**24-1: cycles pfl_nreconfigure is held low.
REQ-004 SHALL have parameter RST_CYC, default 2**24-1: cycles pfl_nreset is held low.
REQ-005 SHALL have parameter WAIT_CYC, default 2**28-1: conf_done timeout in cycles.
REQ-006 SHALL have parameter MAX_RETRY, default 2: reload attempts per page before the page is declared failed.
REQ-007 Ports, in this order:
- clkin_max_100 in 1: sole clock.
- sys_reset in 1: asynchronous, active-high reset.
- fpga_conf_done in 1: FPGA CONF_DONE, asynchronous to the clock.
- page_next in 1: level request to advance to the next user page.
- oper_compl in 1: flash controller finished the boot-page read.
- boot_page in PAGE_W: page index read from flash; valid while oper_compl=1.
- pfl_access out 1: 1 = PFL owns flash; 0 = user flash controller owns flash.
- fl_req out 1: active-low read request to the flash controller.
- fpga_pgm out 3: page select to the PFL, zero-extended from page.
- pfl_nreconfigure out 1: active-low PFL reconfigure.
- pfl_nreset out 1: active-low PFL reset.
- busy out 1: high in every state except IDLE and FAULT.
- cfg_error out 1: sticky configuration failure flag.
- good_page out PAGE_W: last page that configured successfully.

Function
REQ-008 fpga_conf_done SHALL pass through a 2-flop synchronizer; "done" below means the synchronized value.
REQ-009 States SHALL be BOOT_WAIT, BOOT_READ, RECONF, PFL_RST, WAIT_DONE, IDLE, FAULT.
REQ-010 BOOT_WAIT: pfl_access=1, fl_req=1; go to BOOT_READ on done=1.
REQ-011 BOOT_READ: pfl_access=0, fl_req=0. On oper_compl=1, latch page = boot_page (forced to 0 if boot_page >= NUM_PAGES), latch good_page = the same value, and go to IDLE with pfl_access=1 and fl_req=1 on the following cycle.
REQ-012 IDLE: on page_next=1, page SHALL become page+1, wrapping from NUM_PAGES-1 (and from 0) to 1; retry counter cleared; next state RECONF.
REQ-013 RECONF: pfl_nreconfigure=0 for exactly CFG_CYC cycles, then 1; next state PFL_RST.
REQ-014 PFL_RST: pfl_nreset=0 for exactly RST_CYC cycles, then 1; next state WAIT_DONE.
REQ-015 WAIT_DONE: done=1 with the counter below WAIT_CYC SHALL move to IDLE on the next cycle, set good_page=page and clear the retry counter; early exit is required.
REQ-016 WAIT_DONE timeout: if retry < MAX_RETRY, increment retry and return to RECONF with page unchanged; otherwise the page has failed (see REQ-021/022).
REQ-017 page_next SHALL be ignored outside IDLE; no request is queued.
REQ-018 Each state counter SHALL be cleared on state entry and be exactly wide enough for its limit; no wrap-around inside a state.
REQ-019 fpga_pgm SHALL change only in BOOT_READ or on IDLE->RECONF; it stays stable throughout RECONF, PFL_RST and WAIT_DONE.

Reset
REQ-020 While sys_reset=1, and immediately with no clock edge: state=BOOT_WAIT, pfl_access=1, fl_req=1, pfl_nreconfigure=1, pfl_nreset=1, page=0, good_page=0, retry=0, cfg_error=0, busy=1, counters=0, synchronizer flops=0. Reset mid-sequence SHALL abort any pulse in progress.

Configuration
REQ-021 With CFG_SEQ_FALLBACK_EN defined, a failed page SHALL set page=good_page, retry=0 and return to RECONF. If the failed page already equals good_page, it SHALL set page=0 and re-enter RECONF. If page 0 fails, it SHALL set cfg_error=1 and go to FAULT.
REQ-022 Without CFG_SEQ_FALLBACK_EN, a failed page SHALL set cfg_error=1 and go to FAULT, with page held at the failed value.
REQ-023 FAULT SHALL drive pfl_access=1 with all PFL controls deasserted. It SHALL be left only by reset; page_next is ignored.

Verification (NUM_PAGES=3, CFG_CYC=4, RST_CYC=4, WAIT_CYC=16, MAX_RETRY=2)
REQ-024 Boot: reset release, conf_done=1, oper_compl=1 with boot_page=2 -> IDLE, fpga_pgm=3'b010, good_page=2, pfl_access=1.
REQ-025 Advance: in IDLE with page=2, pulse page_next -> fpga_pgm=1; nreconfigure low for exactly 4 cycles, then nreset low for 4 cycles; conf_done high 3 cycles later -> IDLE, good_page=1.
REQ-026 Bad boot index: boot_page=3 -> page=0, good_page=0.
REQ-027 Retry with fallback defined: page 1 never asserts conf_done -> 3 full RECONF/PFL_RST/WAIT_DONE passes on page 1, then fpga_pgm=good_page=2; conf_done then -> IDLE, cfg_error=0.
REQ-028 No fallback: same stimulus as REQ-027 -> after 3 attempts cfg_error=1, state FAULT, fpga_pgm=1; page_next is ignored.
REQ-029 Reset mid-RECONF (cycle 2) -> pfl_nreconfigure=1 and state BOOT_WAIT asynchronously, with no clock edge.
